// File: rtl/ndp_layer_sequencer.sv
// ndp_layer_sequencer
// Command-driven front end for the NDP core input stream. Accepts a job
// descriptor, forwards memory-side words into the core with tlast placed at
// the scratch-pad fill boundary, drives the per-layer core controls, and
// watches the core result stream to report job completion.
//
// Handshake semantics (all streams and the command port): a transfer happens
// on a rising clock edge where valid and ready are both high. A source holds
// its data stable while valid is high and ready is low. Valid never waits on
// ready. The forward path is a pure combinational pass-through in STREAM, so
// a stall on either side holds both sides and every counter.
module ndp_layer_sequencer #(
    parameter int SYS_WIDTH    = 16,
    parameter int WORDS_FIRST  = 2 * SYS_WIDTH + 2,
    parameter int WORDS_NEXT   = 2 * SYS_WIDTH,
    parameter int RESULT_WORDS = 128
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    // job descriptor
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_layers,
    input  logic [15:0] cmd_chunks,
    input  logic [15:0] cmd_relu_mask,
    // memory-side source stream
    input  logic [31:0] src_tdata,
    input  logic        src_tvalid,
    output logic        src_tready,
    // stream into the core
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    // per-layer core controls
    output logic        is_relu_out,
    output logic        is_last_out,
    output logic        read_trigger_out,
    // tap of the core result stream
    input  logic        res_tvalid,
    input  logic        res_tready,
    input  logic        res_tlast,
    // status
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  layer_idx
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SETUP       = 3'd1,
        ST_LAUNCH      = 3'd2,
        ST_STREAM      = 3'd3,
        ST_WAIT_RESULT = 3'd4
    } state_t;

    localparam logic [5:0]  LAST_WORD_FIRST = 6'(WORDS_FIRST - 1);
    localparam logic [5:0]  LAST_WORD_NEXT  = 6'(WORDS_NEXT - 1);
    localparam logic [15:0] LAST_RESULT     = 16'(RESULT_WORDS - 1);

    state_t      state;
    logic [3:0]  layers_q;
    logic [15:0] chunks_q;
    logic [15:0] relu_mask_q;
    logic [5:0]  word_cnt;
    logic [15:0] chunk_cnt;
    logic [15:0] res_cnt;

    logic        streaming;
    logic [5:0]  word_last;
    logic        at_tlast;
    logic        fwd_hs;
    logic        res_hs;

    // Layer 0 chunks carry the activation pair on top of the weights.
    assign word_last = (layer_idx == 4'd0) ? LAST_WORD_FIRST : LAST_WORD_NEXT;
    assign at_tlast  = (word_cnt == word_last) && (chunk_cnt == chunks_q - 16'd1);
    assign streaming = (state == ST_STREAM);
    assign fwd_hs    = streaming && src_tvalid && m_axis_tready;
    assign res_hs    = res_tvalid && res_tready;

    // Zero-latency forward path; everything is held at 0 outside STREAM.
    assign m_axis_tdata  = streaming ? src_tdata : 32'd0;
    assign m_axis_tvalid = streaming && src_tvalid;
    assign m_axis_tlast  = streaming && at_tlast;
    assign src_tready    = streaming && m_axis_tready;
    assign cmd_ready     = (state == ST_IDLE);

    // Job sequencing FSM with all control and status outputs registered.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state            <= ST_IDLE;
            layers_q         <= 4'd1;
            chunks_q         <= 16'd1;
            relu_mask_q      <= 16'd0;
            word_cnt         <= 6'd0;
            chunk_cnt        <= 16'd0;
            res_cnt          <= 16'd0;
            is_relu_out      <= 1'b0;
            is_last_out      <= 1'b0;
            read_trigger_out <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            layer_idx        <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        layers_q    <= (cmd_layers == 4'd0) ? 4'd1 : cmd_layers;
                        chunks_q    <= (cmd_chunks == 16'd0) ? 16'd1 : cmd_chunks;
                        relu_mask_q <= cmd_relu_mask;
                        err         <= 1'b0;
                        layer_idx   <= 4'd0;
                        busy        <= 1'b1;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    // Config settles one cycle ahead of the trigger edge.
                    is_relu_out <= relu_mask_q[layer_idx];
                    is_last_out <= (layer_idx == layers_q - 4'd1);
                    state       <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    read_trigger_out <= ~read_trigger_out;
                    word_cnt         <= 6'd0;
                    chunk_cnt        <= 16'd0;
                    res_cnt          <= 16'd0;
                    state            <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (fwd_hs) begin
                        if (word_cnt == word_last) begin
                            word_cnt  <= 6'd0;
                            chunk_cnt <= chunk_cnt + 16'd1;
                        end else begin
                            word_cnt <= word_cnt + 6'd1;
                        end
                        if (at_tlast) begin
                            if (is_last_out) begin
                                state <= ST_WAIT_RESULT;
                            end else begin
                                layer_idx <= layer_idx + 4'd1;
                                state     <= ST_SETUP;
                            end
                        end
                    end
                end
                ST_WAIT_RESULT: begin
                    if (res_hs) begin
                        res_cnt <= res_cnt + 16'd1;
                        if (res_tlast) begin
                            if (res_cnt != LAST_RESULT) begin
                                err <= 1'b1;
                            end
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            layer_idx <= 4'd0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ndp_layer_sequencer.sv
// Self-checking bench for ndp_layer_sequencer. A job-level reference model
// derives, from the descriptor alone, how many words each layer carries, where
// tlast falls, the per-layer ReLU/last flags, the trigger sequence and the
// expected error flag; a scoreboard queue holds the source words in order.
module tb_ndp_layer_sequencer;

    logic        clk;
    logic        axi_aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_layers;
    logic [15:0] cmd_chunks;
    logic [15:0] cmd_relu_mask;
    logic [31:0] src_tdata;
    logic        src_tvalid;
    logic        src_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        is_relu_out;
    logic        is_last_out;
    logic        read_trigger_out;
    logic        res_tvalid;
    logic        res_tready;
    logic        res_tlast;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  layer_idx;

    int          vectors = 0;
    int          miscompares = 0;
    logic        exp_trig;
    logic [31:0] exp_q[$];
    logic [31:0] src_mem[$];
    int          src_idx;
    bit          aborted;

    ndp_layer_sequencer dut (
        .axi_aclk         (clk),
        .axi_aresetn      (axi_aresetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_layers       (cmd_layers),
        .cmd_chunks       (cmd_chunks),
        .cmd_relu_mask    (cmd_relu_mask),
        .src_tdata        (src_tdata),
        .src_tvalid       (src_tvalid),
        .src_tready       (src_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tready    (m_axis_tready),
        .is_relu_out      (is_relu_out),
        .is_last_out      (is_last_out),
        .read_trigger_out (read_trigger_out),
        .res_tvalid       (res_tvalid),
        .res_tready       (res_tready),
        .res_tlast        (res_tlast),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .layer_idx        (layer_idx)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic report_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s observed=timeout expected=completion", tag);
        report_and_finish();
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check1({tag, "_trigger"}, read_trigger_out, 1'b0);
        check1({tag, "_is_relu"}, is_relu_out, 1'b0);
        check1({tag, "_is_last"}, is_last_out, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_err"}, err, 1'b0);
        check32({tag, "_layer_idx"}, 32'(layer_idx), 32'd0);
        check1({tag, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        check1({tag, "_m_tlast"}, m_axis_tlast, 1'b0);
        check1({tag, "_src_tready"}, src_tready, 1'b0);
    endtask

    // One complete job: descriptor, every layer's stream, then the result packet.
    // abort_after > 0 stops the job after that many words of layer 0.
    task automatic run_job(input logic [3:0] l_in, input logic [15:0] c_in,
                           input logic [15:0] mask, input bit stall,
                           input int res_len, input int abort_after,
                           output bit was_aborted);
        int nl;
        int nc;
        int total;
        int k;
        int cyc;
        logic [31:0] w;
        bit exp_err;

        was_aborted = 1'b0;
        nl = (l_in == 4'd0) ? 1 : int'(l_in);
        nc = (c_in == 16'd0) ? 1 : int'(c_in);
        exp_err = (res_len != 128);
        total = 0;
        for (int l = 0; l < nl; l++) total += nc * ((l == 0) ? 34 : 32);
        src_mem.delete();
        exp_q.delete();
        for (int i = 0; i < total; i++) begin
            w = $urandom;
            src_mem.push_back(w);
            exp_q.push_back(w);
        end
        src_idx = 0;

        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_layers = l_in;
        cmd_chunks = c_in;
        cmd_relu_mask = mask;
        #1;
        check1("cmd_ready_idle", cmd_ready, 1'b1);

        for (int l = 0; l < nl; l++) begin
            int n;
            int cnt;
            bit first;
            logic old_trig;
            n = nc * ((l == 0) ? 34 : 32);
            cnt = 0;
            cyc = 0;
            first = 1'b1;
            old_trig = exp_trig;

            // SETUP cycle: forward path must be closed and stray result
            // traffic must not matter.
            @(negedge clk);
            cmd_valid = 1'b0;
            src_tvalid = 1'b1;
            src_tdata = src_mem[src_idx];
            m_axis_tready = 1'b1;
            res_tvalid = 1'b1;
            res_tready = 1'b1;
            res_tlast = 1'b1;
            #1;
            check1("setup_trigger_held", read_trigger_out, old_trig);
            check32("setup_layer_idx", 32'(layer_idx), 32'(l));
            check1("setup_m_tvalid_closed", m_axis_tvalid, 1'b0);
            check1("setup_src_tready_closed", src_tready, 1'b0);
            check1("setup_busy", busy, 1'b1);
            check1("setup_cmd_ready_low", cmd_ready, 1'b0);
            check1("setup_err_clear", err, 1'b0);

            // LAUNCH cycle: per-layer config already visible.
            @(negedge clk);
            res_tvalid = 1'b0;
            res_tready = 1'b0;
            res_tlast = 1'b0;
            #1;
            check1("launch_is_relu", is_relu_out, mask[l]);
            check1("launch_is_last", is_last_out, (l == nl - 1));
            check1("launch_m_tvalid_closed", m_axis_tvalid, 1'b0);
            exp_trig = ~exp_trig;

            forever begin
                @(negedge clk);
                if (stall) begin
                    src_tvalid = 1'($urandom_range(0, 1));
                    m_axis_tready = 1'($urandom_range(0, 1));
                end else begin
                    src_tvalid = 1'b1;
                    m_axis_tready = 1'b1;
                end
                src_tdata = src_mem[src_idx];
                #1;
                if (first) begin
                    check1("trigger_toggled", read_trigger_out, exp_trig);
                    first = 1'b0;
                end
                check1("fwd_tvalid", m_axis_tvalid, src_tvalid);
                check1("fwd_src_tready", src_tready, m_axis_tready);
                check1("fwd_tlast", m_axis_tlast, (cnt == n - 1));
                if (src_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check32("fwd_extra_word", m_axis_tdata, 32'hxxxxxxxx);
                    end else begin
                        check32("fwd_tdata", m_axis_tdata, exp_q.pop_front());
                    end
                    src_idx++;
                    cnt++;
                    if (cnt == n) break;
                    if (abort_after > 0 && cnt == abort_after) begin
                        was_aborted = 1'b1;
                        return;
                    end
                end
                cyc++;
                if (cyc > 4000) timeout("stream_budget");
            end
        end

        // Result packet from the core.
        k = 0;
        cyc = 0;
        while (k < res_len) begin
            @(negedge clk);
            src_tvalid = 1'b0;
            m_axis_tready = 1'b0;
            res_tvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            res_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            res_tlast = (k == res_len - 1);
            #1;
            check1("wait_done_low", done, 1'b0);
            check1("wait_busy", busy, 1'b1);
            if (res_tvalid && res_tready) k++;
            cyc++;
            if (cyc > 4000) timeout("result_budget");
        end
        @(negedge clk);
        res_tvalid = 1'b0;
        res_tready = 1'b0;
        res_tlast = 1'b0;
        #1;
        check1("end_done_pulse", done, 1'b1);
        check1("end_busy_clear", busy, 1'b0);
        check1("end_err", err, exp_err);
        check32("end_layer_idx", 32'(layer_idx), 32'd0);
        check1("end_cmd_ready", cmd_ready, 1'b1);
        check32("end_words_left", 32'(exp_q.size()), 32'd0);
        check32("end_words_taken", 32'(src_idx), 32'(total));
        @(negedge clk);
        #1;
        check1("end_done_one_cycle", done, 1'b0);
        check1("end_err_sticky", err, exp_err);
    endtask

    // Directed sequence of jobs with randomized data, masks and stalls.
    initial begin
        axi_aresetn = 1'b0;
        cmd_valid = 1'b0;
        cmd_layers = 4'd0;
        cmd_chunks = 16'd0;
        cmd_relu_mask = 16'd0;
        src_tdata = 32'd0;
        src_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        res_tvalid = 1'b0;
        res_tready = 1'b0;
        res_tlast = 1'b0;
        exp_trig = 1'b0;
        src_idx = 0;

        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_values("rst");
        @(negedge clk);
        axi_aresetn = 1'b1;

        // Single layer, single chunk, ReLU on.
        run_job(4'd1, 16'd1, 16'h0001, 1'b0, 128, 0, aborted);
        // Two layers, two chunks, no stalls.
        run_job(4'd2, 16'd2, 16'($urandom), 1'b0, 128, 0, aborted);
        // Same shape with random stalls on both sides.
        run_job(4'd2, 16'd2, 16'($urandom), 1'b1, 128, 0, aborted);
        // Zero layers / zero chunks behave as one of each.
        run_job(4'd0, 16'd0, 16'($urandom), 1'b0, 128, 0, aborted);
        // Short result packet: tlast on word 100 flags an error.
        run_job(4'd1, 16'd1, 16'($urandom), 1'b0, 100, 0, aborted);
        // Next accept clears the sticky error.
        run_job(4'($urandom_range(1, 4)), 16'($urandom_range(1, 3)),
                16'($urandom), 1'b1, 128, 0, aborted);

        // Reset in the middle of layer 0, then a fresh job.
        run_job(4'd2, 16'd1, 16'hffff, 1'b0, 128, 20, aborted);
        check1("abort_reached", aborted, 1'b1);
        @(negedge clk);
        axi_aresetn = 1'b0;
        src_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        #1;
        check_reset_values("midjob_rst");
        exp_trig = 1'b0;
        @(negedge clk);
        axi_aresetn = 1'b1;
        run_job(4'd1, 16'd1, 16'($urandom), 1'b1, 128, 0, aborted);

        report_and_finish();
    end

endmodule
